decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port input_valid_i  input  1  upstream instruction valid (from fetch output_valid_o).
REQ-004 SHALL have port input_ready_o  output  1  decode can accept (to fetch output_ready_i).
REQ-005 SHALL have port instr_i  input  32  RV32I instruction word.
REQ-006 SHALL have port pc_i  input  32  address of instr_i.
REQ-007 SHALL have port branch_i  input  1  flush request from downstream taken branch/jump.
REQ-008 SHALL have port output_valid_o  output  1  decoded bundle valid.
REQ-009 SHALL have port output_ready_i  input  1  downstream can accept.
REQ-010 SHALL have ports pc_o 32, rs1_o 5, rs2_o 5, rd_o 5, imm_o 32, func3_o 3, alt_o 1, use_imm_o 1, unit_o 2 (00 ALU, 01 BRANCH, 10 LSU, 11 SYSTEM), store_o 1 -- all outputs, registered.
REQ-011 SHALL have port illegal_o  output  1  illegal-instruction flag (present only with DECODE_ILLEGAL_EN).

Function
REQ-012 SHALL be one registered stage with two states: EMPTY (output_valid_o=0) and FULL (output_valid_o=1).
REQ-013 input_ready_o SHALL equal (!output_valid_o | output_ready_i), combinational, no dependency on input_valid_i.
REQ-014 On input_valid_i & input_ready_o & !branch_i, SHALL load decoded fields next cycle and be FULL; latency 1 cycle.
REQ-015 FULL with output_ready_i=1 and no accepted input SHALL go EMPTY next cycle.
REQ-016 FULL with output_ready_i=0 SHALL hold every output bit unchanged.
REQ-017 Simultaneous drain and accept SHALL stay FULL with the new bundle; no bubble.
REQ-018 branch_i=1 SHALL force EMPTY next cycle and discard any input offered that cycle, regardless of other inputs.
REQ-019 opcode=instr_i[6:0]; rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20]; alt_o=instr_i[30] for OP and for OP-IMM func3=101, else 0.
REQ-020 Immediates SHALL be sign-extended from instr_i[31]: I (LOAD, OP-IMM, JALR, SYSTEM), S (STORE), B and J (bit 0 = 0), U (low 12 bits zero); imm_o=0 for OP.
REQ-021 unit_o: OP/OP-IMM/LUI/AUIPC -> ALU; JAL/JALR/BRANCH -> BRANCH; LOAD/STORE -> LSU; SYSTEM/MISC-MEM -> SYSTEM.
REQ-022 use_imm_o=1 for all opcodes except OP and BRANCH.
REQ-023 rd_o SHALL be 0 for STORE, BRANCH, MISC-MEM; rs1_o=0 for LUI/AUIPC/JAL; rs2_o=0 for all but OP/STORE/BRANCH.
REQ-024 store_o=1 only for STORE.
REQ-025 pc_o SHALL carry pc_i of the accepted instruction unchanged.

Reset
REQ-026 rst_i=1 SHALL force EMPTY next edge; all registered outputs SHALL be 0 (including illegal_o).
REQ-027 Reset SHALL override branch_i and any handshake in the same cycle; bundle in flight SHALL be dropped.
REQ-028 input_ready_o SHALL be 1 in the cycle after reset is released.

Configuration
REQ-029 Macro DECODE_ILLEGAL_EN defined: illegal_o=1 when instr_i[1:0]!=11, opcode unsupported, OP funct7 not 0000000/0100000, or funct7=0100000 with func3 other than 000/101; illegal bundles still pass the handshake.
REQ-030 Macro undefined: illegal_o absent; any such instruction SHALL decode as NOP (unit ALU, rd/rs1/rs2=0, imm=0, use_imm=1, func3=0).

Verification
REQ-031 instr 0xFFF10093, pc 0x100, ready=1 -> next cycle valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, func3=0, unit=ALU, use_imm=1, pc_o=0x100.
REQ-032 instr 0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC, unit=BRANCH, use_imm=0.
REQ-033 instr 0x123452B7 (lui x5) accepted, output_ready_i=0 for 3 cycles with 0x00000013 offered -> input_ready_o=0, outputs hold rd=5, imm=0x12345000; ready=1 -> next bundle loaded without bubble.
REQ-034 FULL, branch_i=1 with valid input offered -> output_valid_o=0 next cycle, offered instruction never appears.
REQ-035 instr 0x00000000 -> with DECODE_ILLEGAL_EN illegal_o=1; without it NOP bundle (rd=0, imm=0, unit=ALU).
REQ-036 rst_i=1 while FULL and stalled -> next cycle all outputs 0, input_ready_o=1 after release.

Source files
------------

// File: rtl/decode.sv
// RV32I decode stage: one registered valid/ready slot with flush.
// Ports: clk_i, rst_i, input_valid_i/input_ready_o, instr_i, pc_i,
// branch_i, output_valid_o/output_ready_i, decoded bundle outputs.
// Define DECODE_ILLEGAL_EN to add illegal_o; otherwise bad encodings
// decode as a NOP bundle.
module decode (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        branch_i,
  output logic        output_valid_o,
  input  logic        output_ready_i,
  output logic [31:0] pc_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic [2:0]  func3_o,
  output logic        alt_o,
  output logic        use_imm_o,
  output logic [1:0]  unit_o,
`ifdef DECODE_ILLEGAL_EN
  output logic        illegal_o,
`endif
  output logic        store_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [1:0] U_ALU = 2'b00;
  localparam logic [1:0] U_BR  = 2'b01;
  localparam logic [1:0] U_LSU = 2'b10;
  localparam logic [1:0] U_SYS = 2'b11;

  state_t state_q, state_d;
  logic   load;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic        legal;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm;
  logic [2:0]  d_f3;
  logic        d_alt, d_use_imm, d_store;
  logic [1:0]  d_unit;

  assign output_valid_o = (state_q == FULL);
  assign input_ready_o  = !output_valid_o | output_ready_i;
  assign load = input_valid_i & input_ready_o & !branch_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (branch_i)
      state_d = EMPTY;
    else if (load)
      state_d = FULL;
    else if (output_ready_i)
      state_d = EMPTY;
  end

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                  instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    legal     = 1'b1;
    d_rs1     = instr_i[19:15];
    d_rs2     = 5'd0;
    d_rd      = instr_i[11:7];
    d_imm     = 32'd0;
    d_f3      = f3;
    d_alt     = 1'b0;
    d_use_imm = 1'b1;
    d_store   = 1'b0;
    d_unit    = U_ALU;
    unique case (1'b1)
      (opc == OP_LUI): begin
        d_rs1 = 5'd0;
        d_imm = imm_u;
      end
      (opc == OP_AUIPC): begin
        d_rs1 = 5'd0;
        d_imm = imm_u;
      end
      (opc == OP_JAL): begin
        d_rs1  = 5'd0;
        d_imm  = imm_j;
        d_unit = U_BR;
      end
      (opc == OP_JALR): begin
        d_imm  = imm_i;
        d_unit = U_BR;
      end
      (opc == OP_BR): begin
        d_rs2     = instr_i[24:20];
        d_rd      = 5'd0;
        d_imm     = imm_b;
        d_use_imm = 1'b0;
        d_unit    = U_BR;
      end
      (opc == OP_LOAD): begin
        d_imm  = imm_i;
        d_unit = U_LSU;
      end
      (opc == OP_STORE): begin
        d_rs2   = instr_i[24:20];
        d_rd    = 5'd0;
        d_imm   = imm_s;
        d_store = 1'b1;
        d_unit  = U_LSU;
      end
      (opc == OP_IMM): begin
        d_imm = imm_i;
        d_alt = (f3 == 3'b101) & instr_i[30];
      end
      (opc == OP_OP): begin
        d_rs2     = instr_i[24:20];
        d_alt     = instr_i[30];
        d_use_imm = 1'b0;
        // only base and "alternate" (SUB/SRA) funct7 encodings exist
        if (f7 == 7'b0100000)
          legal = (f3 == 3'b000) | (f3 == 3'b101);
        else
          legal = (f7 == 7'b0000000);
      end
      (opc == OP_FENCE): begin
        d_rd   = 5'd0;
        d_imm  = imm_i;
        d_unit = U_SYS;
      end
      (opc == OP_SYS): begin
        d_imm  = imm_i;
        d_unit = U_SYS;
      end
      default: legal = 1'b0;
    endcase
    // opcode compare covers instr_i[1:0] != 2'b11 as well
    if (!legal) begin
      d_rs1     = 5'd0;
      d_rs2     = 5'd0;
      d_rd      = 5'd0;
      d_imm     = 32'd0;
      d_f3      = 3'd0;
      d_alt     = 1'b0;
      d_use_imm = 1'b1;
      d_store   = 1'b0;
      d_unit    = U_ALU;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o      <= '0;
      rs1_o     <= '0;
      rs2_o     <= '0;
      rd_o      <= '0;
      imm_o     <= '0;
      func3_o   <= '0;
      alt_o     <= 1'b0;
      use_imm_o <= 1'b0;
      unit_o    <= '0;
      store_o   <= 1'b0;
    end else if (load) begin
      pc_o      <= pc_i;
      rs1_o     <= d_rs1;
      rs2_o     <= d_rs2;
      rd_o      <= d_rd;
      imm_o     <= d_imm;
      func3_o   <= d_f3;
      alt_o     <= d_alt;
      use_imm_o <= d_use_imm;
      unit_o    <= d_unit;
      store_o   <= d_store;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)     illegal_o <= 1'b0;
    else if (load) illegal_o <= !legal;
  end
`endif

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for decode.
// Inputs change 1 time unit after posedge; outputs checked there.
module tb_decode;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        input_valid_i;
  logic        input_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        branch_i;
  logic        output_valid_o;
  logic        output_ready_i;
  logic [31:0] pc_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o;
  logic [2:0]  func3_o;
  logic        alt_o, use_imm_o, store_o;
  logic [1:0]  unit_o;
`ifdef DECODE_ILLEGAL_EN
  logic        illegal_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  decode dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .input_valid_i  (input_valid_i),
    .input_ready_o  (input_ready_o),
    .instr_i        (instr_i),
    .pc_i           (pc_i),
    .branch_i       (branch_i),
    .output_valid_o (output_valid_o),
    .output_ready_i (output_ready_i),
    .pc_o           (pc_o),
    .rs1_o          (rs1_o),
    .rs2_o          (rs2_o),
    .rd_o           (rd_o),
    .imm_o          (imm_o),
    .func3_o        (func3_o),
    .alt_o          (alt_o),
    .use_imm_o      (use_imm_o),
    .unit_o         (unit_o),
`ifdef DECODE_ILLEGAL_EN
    .illegal_o      (illegal_o),
`endif
    .store_o        (store_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    input_valid_i = 1'b1;
    instr_i = ins;
    pc_i = pc;
  endtask

  task automatic chk_fields(input string t,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            input logic [2:0] f3, input logic [1:0] un,
                            input logic ui, input logic al, input logic st);
    check({t, ".rd"},   32'(rd_o), 32'(rd));
    check({t, ".rs1"},  32'(rs1_o), 32'(rs1));
    check({t, ".rs2"},  32'(rs2_o), 32'(rs2));
    check({t, ".imm"},  imm_o, imm);
    check({t, ".f3"},   32'(func3_o), 32'(f3));
    check({t, ".unit"}, 32'(unit_o), 32'(un));
    check({t, ".uimm"}, 32'(use_imm_o), 32'(ui));
    check({t, ".alt"},  32'(alt_o), 32'(al));
    check({t, ".st"},   32'(store_o), 32'(st));
  endtask

  initial begin
    rst_i = 1'b1;
    input_valid_i = 1'b0;
    instr_i = '0;
    pc_i = '0;
    branch_i = 1'b0;
    output_ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst.valid", 32'(output_valid_o), 0);
    check("rst.ready", 32'(input_ready_o), 1);
    check("rst.pc", pc_o, 0);
    chk_fields("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // addi x1,x2,-1
    output_ready_i = 1'b1;
    offer(32'hFFF10093, 32'h100);
    step();
    check("addi.valid", 32'(output_valid_o), 1);
    check("addi.pc", pc_o, 32'h100);
    chk_fields("addi", 1, 2, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0);

    // beq x1,x2,-4
    offer(32'hFE208EE3, 32'h104);
    step();
    check("beq.valid", 32'(output_valid_o), 1);
    chk_fields("beq", 0, 1, 2, 32'hFFFFFFFC, 0, 1, 0, 0, 0);

    // sw x3,8(x4)
    offer(32'h00322423, 32'h108);
    step();
    chk_fields("sw", 0, 4, 3, 32'd8, 2, 2, 1, 0, 1);

    // sub x5,x6,x7
    offer(32'h407302B3, 32'h10C);
    step();
    chk_fields("sub", 5, 6, 7, 0, 0, 0, 0, 1, 0);

    // srai x1,x2,3
    offer(32'h40315093, 32'h110);
    step();
    chk_fields("srai", 1, 2, 0, 32'h403, 5, 0, 1, 1, 0);

    // jal x1,+16
    offer(32'h010000EF, 32'h114);
    step();
    chk_fields("jal", 1, 0, 0, 32'd16, 0, 1, 1, 0, 0);

    // drain with no new input
    input_valid_i = 1'b0;
    step();
    check("drain.valid", 32'(output_valid_o), 0);

    // lui x5, then stall three cycles with a nop offered
    offer(32'h123452B7, 32'h200);
    step();
    check("lui.valid", 32'(output_valid_o), 1);
    output_ready_i = 1'b0;
    offer(32'h00000013, 32'h204);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.ready", 32'(input_ready_o), 0);
      step();
      check("stall.valid", 32'(output_valid_o), 1);
      check("stall.rd", 32'(rd_o), 5);
      check("stall.imm", imm_o, 32'h12345000);
      check("stall.pc", pc_o, 32'h200);
    end
    output_ready_i = 1'b1;
    #1;
    check("unstall.ready", 32'(input_ready_o), 1);
    step();
    check("nobubble.valid", 32'(output_valid_o), 1);
    check("nobubble.pc", pc_o, 32'h204);
    chk_fields("nop", 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // flush while full, with an instruction offered
    branch_i = 1'b1;
    offer(32'h00500093, 32'h300);
    step();
    branch_i = 1'b0;
    input_valid_i = 1'b0;
    check("flush.valid", 32'(output_valid_o), 0);
    step();
    check("flush.gone", 32'(output_valid_o), 0);
    check("flush.pcold", pc_o, 32'h204);

    // all-zero word: illegal
    offer(32'h00000000, 32'h400);
    step();
    check("ill.valid", 32'(output_valid_o), 1);
    chk_fields("ill", 0, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef DECODE_ILLEGAL_EN
    check("ill.flag", 32'(illegal_o), 1);
`endif

    // bad OP funct7 also becomes a nop bundle
    offer(32'h02208033, 32'h404);
    step();
    chk_fields("badop", 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // reset while full and stalled
    offer(32'h123452B7, 32'h500);
    step();
    output_ready_i = 1'b0;
    input_valid_i = 1'b0;
    step();
    check("pre.valid", 32'(output_valid_o), 1);
    rst_i = 1'b1;
    branch_i = 1'b1;
    offer(32'h00000013, 32'h504);
    step();
    rst_i = 1'b0;
    branch_i = 1'b0;
    input_valid_i = 1'b0;
    #1;
    check("rst2.valid", 32'(output_valid_o), 0);
    check("rst2.ready", 32'(input_ready_o), 1);
    check("rst2.pc", pc_o, 0);
    chk_fields("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DECODE_ILLEGAL_EN
    check("rst2.ill", 32'(illegal_o), 0);
`endif
    step();
    check("rst2.stay", 32'(output_valid_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
